// File: rtl/stack_op_if.sv
// Instruction and operand-stack port bundle for stack_op_engine.
// master = decode stage + stack storage, slave = the engine.
interface stack_op_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_imm;

  logic             stk_push;
  logic             stk_pop;
  logic             stk_tos;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;

  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [DW-1:0]    depth;
  logic             err_under;
  logic             err_over;

  modport master (
    output op_valid, op_code, op_imm, stk_dout,
    input  op_ready, stk_push, stk_pop, stk_tos, stk_din,
           result, result_valid, depth, err_under, err_over
  );

  modport slave (
    input  op_valid, op_code, op_imm, stk_dout,
    output op_ready, stk_push, stk_pop, stk_tos, stk_din,
           result, result_valid, depth, err_under, err_over
  );
endinterface

// File: rtl/stack_op_engine.sv
// Stack-machine sequencer: one instruction at a time, result_valid 2..6 cycles after accept.
// op_ready is high only in IDLE; illegal instructions take a one-cycle FAULT detour.
module stack_op_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  stack_op_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_DUP  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_POPA, S_READA, S_POPB, S_READB, S_PUSHR, S_PUSH2, S_FAULT
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_result;
  logic             r_push;
  logic             r_pop;
  logic             r_tos;
  logic             r_rdy;
  logic             r_rv;
  logic             r_err_under;
  logic             r_err_over;
  logic [DW-1:0]    r_depth;

  logic             w_accept;
  logic             w_under;
  logic             w_over;

  assign w_accept = bus.op_valid & r_rdy;

  // DUP pops one and pushes two, so it needs one free slot just like PUSH.
  always_comb begin
    w_under = 1'b0;
    w_over  = 1'b0;
    case (bus.op_code)
      OP_POP, OP_NOT: w_under = (r_depth == '0);
      OP_DUP: begin
        w_under = (r_depth == '0);
        w_over  = (r_depth >= DW'(DEPTH));
      end
      OP_ADD, OP_SUB, OP_AND: w_under = (r_depth < DW'(2));
      OP_PUSH: w_over = (r_depth >= DW'(DEPTH));
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_a         <= '0;
      r_din       <= '0;
      r_result    <= '0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_tos       <= 1'b0;
      r_rdy       <= 1'b1;
      r_rv        <= 1'b0;
      r_err_under <= 1'b0;
      r_err_over  <= 1'b0;
      r_depth     <= '0;
    end else begin
      r_push <= 1'b0;
      r_pop  <= 1'b0;
      r_tos  <= 1'b0;
      r_din  <= '0;
      r_rv   <= 1'b0;
      r_rdy  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (w_accept && bus.op_code != OP_NOP) begin
            r_op  <= bus.op_code;
            r_rdy <= 1'b0;
            if (w_under) begin
              r_state     <= S_FAULT;
              r_err_under <= 1'b1;
            end else if (w_over) begin
              r_state    <= S_FAULT;
              r_err_over <= 1'b1;
            end else if (bus.op_code == OP_PUSH) begin
              r_state <= S_PUSHR;
              r_push  <= 1'b1;
              r_din   <= bus.op_imm;
            end else begin
              r_state <= S_POPA;
              r_pop   <= 1'b1;
            end
          end
        end
        S_POPA: begin
          r_depth <= r_depth - DW'(1);
          r_state <= S_READA;
          r_tos   <= 1'b1;
        end
        S_READA: begin
          r_a <= bus.stk_dout;
          case (r_op)
            OP_POP: begin
              r_result <= bus.stk_dout;
              r_rv     <= 1'b1;
              r_rdy    <= 1'b1;
              r_state  <= S_IDLE;
            end
            OP_NOT: begin
              r_state <= S_PUSHR;
              r_push  <= 1'b1;
              r_din   <= ~bus.stk_dout;
            end
            OP_DUP: begin
              r_state <= S_PUSHR;
              r_push  <= 1'b1;
              r_din   <= bus.stk_dout;
            end
            default: begin
              r_state <= S_POPB;
              r_pop   <= 1'b1;
            end
          endcase
        end
        S_POPB: begin
          r_depth <= r_depth - DW'(1);
          r_state <= S_READB;
          r_tos   <= 1'b1;
        end
        S_READB: begin
          r_state <= S_PUSHR;
          r_push  <= 1'b1;
          case (r_op)
            OP_ADD:  r_din <= bus.stk_dout + r_a;
            OP_SUB:  r_din <= bus.stk_dout - r_a;
            default: r_din <= bus.stk_dout & r_a;
          endcase
        end
        S_PUSHR: begin
          r_depth <= r_depth + DW'(1);
          if (r_op == OP_DUP) begin
            r_state <= S_PUSH2;
            r_push  <= 1'b1;
            r_din   <= r_din;
          end else begin
            r_result <= r_din;
            r_rv     <= 1'b1;
            r_rdy    <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        S_PUSH2: begin
          r_depth  <= r_depth + DW'(1);
          r_result <= r_din;
          r_rv     <= 1'b1;
          r_rdy    <= 1'b1;
          r_state  <= S_IDLE;
        end
        S_FAULT: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready     = r_rdy;
  assign bus.stk_push     = r_push;
  assign bus.stk_pop      = r_pop;
  assign bus.stk_tos      = r_tos;
  assign bus.stk_din      = r_din;
  assign bus.result       = r_result;
  assign bus.result_valid = r_rv;
  assign bus.depth        = r_depth;
  assign bus.err_under    = r_err_under;
  assign bus.err_over     = r_err_over;
endmodule

// File: doc/stack_op_engine.md
# stack_op_engine

Stack-machine execution sequencer that drives the push/pop/top-of-stack interface of the processor's operand stack. It accepts one stack instruction at a time over a valid/ready handshake and sequences the pop, read, compute and push strobes on the stack port. It computes ALU results internally and tracks stack occupancy to block underflow and overflow. It sits between the instruction decode stage and the operand stack.

## Interface
- WIDTH, 8, data width of the stack entries and of the ALU.
- DEPTH, 5, stack capacity in entries. The occupancy counter saturates its checks at this value.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  instruction present.
- op_ready  out  1  engine idle and able to accept an instruction.
- op_code  in  3  000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 NOT, 111 DUP.
- op_imm  in  WIDTH  immediate for PUSH.
- stk_push  out  1  stack push strobe.
- stk_pop  out  1  stack pop strobe.
- stk_tos  out  1  stack read enable.
- stk_din  out  WIDTH  data to push.
- stk_dout  in  WIDTH  stack read data; valid combinationally while stk_tos=1.
- result  out  WIDTH  last value pushed, or the popped value for POP.
- result_valid  out  1  one-cycle pulse per completed non-NOP instruction.
- depth  out  $clog2(DEPTH+1)  current occupancy.
- err_under  out  1  sticky underflow flag.
- err_over  out  1  sticky overflow flag.

## Operation
- **Stack port semantics.**
  - The stack pointer addresses one slot above the most recently pushed entry.
  - Reading an operand therefore takes two cycles: a pop cycle (stk_pop=1), then a read cycle (stk_tos=1) that samples stk_dout.
  - stk_push and stk_pop are never asserted in the same cycle.
  - stk_din is 0 whenever stk_push=0.
- **FSM states:** IDLE, POPA, READA, POPB, READB, PUSHR, PUSH2, FAULT.
- **IDLE.**
  - op_ready=1 only in IDLE.
  - An instruction is accepted when op_valid & op_ready.
  - All legality checks are made at acceptance, against depth.
- **Sequences after acceptance:**
  - PUSH: PUSHR with stk_din=op_imm (latched at acceptance).
  - POP: POPA, READA.
  - NOT: POPA, READA, PUSHR.
  - DUP: POPA, READA, PUSHR, PUSH2 (pushes A twice).
  - ADD/SUB/AND: POPA, READA, POPB, READB, PUSHR.
  - NOP: stays in IDLE; op_ready remains 1; no result_valid.
- **Operands and arithmetic.**
  - A = top entry, captured in READA. B = next entry, captured in READB.
  - ADD = B+A, SUB = B−A, AND = B&A, NOT = ~A.
  - All results are modulo 2^WIDTH; carry and borrow are discarded.
- **Occupancy (depth) updates:**
  - +1 on every stk_push cycle.
  - −1 on every stk_pop cycle.
- **Underflow.**
  - Condition: POP/NOT/DUP with depth=0, or ADD/SUB/AND with depth<2.
  - Action: go to FAULT, set err_under.
- **Overflow.**
  - Condition: PUSH with depth=DEPTH, or DUP with depth=DEPTH (checked after the pop, i.e. DUP needs depth<DEPTH).
  - Action: go to FAULT, set err_over.
- **FAULT.**
  - Lasts one cycle.
  - No stack strobes and no result_valid; depth is unchanged.
  - Returns to IDLE.
- err_under and err_over are cleared only by rst. Further instructions still execute normally while the flags are set.

## Timing
- **Reset values:**
  - State IDLE; op_ready=1.
  - stk_push, stk_pop and stk_tos = 0; stk_din = 0.
  - result = 0, result_valid = 0, depth = 0, err_under = 0, err_over = 0.
- **Asserting rst:** all strobes drop immediately (asynchronous) in any state, including mid-sequence. The engine assumes an empty stack afterwards, so the system reset must also reinitialise the stack pointer.
- **Strobes** are registered Moore outputs of the state and are asserted for exactly one cycle per state.
- **Latency from the acceptance edge to the result_valid pulse:**
  - PUSH: 2 cycles.
  - POP: 3 cycles.
  - NOT: 4 cycles.
  - DUP: 5 cycles.
  - ADD/SUB/AND: 6 cycles.
  - FAULT: no pulse; op_ready returns after 2 cycles.
- result is updated in the same cycle that result_valid is asserted, and holds until the next completion.
- **Back-to-back instructions:** the next instruction may be accepted in the cycle result_valid is high, because the engine is already back in IDLE.

## Test plan
- **ADD.** Reset; PUSH 0x03, PUSH 0x05, ADD → result=0x08; depth sequence 1,2,1,0,1; strobe order push,push,pop,tos,pop,tos,push; no errors.
- **SUB wrap.** PUSH 0x02, PUSH 0x07, SUB → result=0xFB (2−7 mod 256); depth=1.
- **Underflow.** From empty: PUSH 0x09, then ADD → err_under=1, no stack strobes during ADD, depth stays 1, no result_valid. A following POP returns result=0x09.
- **Overflow.** Five PUSHes (0x10..0x14), then PUSH 0x20 → err_over=1, depth stays 5. POP → result=0x14.
- **DUP/NOT.** PUSH 0x5A, DUP, NOT, POP → results 0x5A, 0xA5, 0xA5; final depth=1. NOP produces no result_valid.
- **Reset mid-op.** Start ADD at depth 2, assert rst during READB → strobes low the same cycle; after release op_ready=1, depth=0, and all flags and result are 0.
